// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, FSM states and
// the opcode classifier used by the decode step.
package alu_seq_pkg;

  localparam int OPC_W = 5;

  // Two-operand ALU group
  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b01010;
  // 64-bit result group
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;
  // One-operand group
  localparam logic [OPC_W-1:0] OP_NEG = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b10010;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, TRAP, ERR
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
  } op_class_t;

  // Map an opcode onto the execution sequence it needs.
  function automatic op_class_t classify(input logic [OPC_W-1:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU;
      OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_sequencer_onehot.sv
// Register-file select decoder: turns a register index into a one-hot
// R*in / R*out strobe vector. Out-of-range indices select nothing.
module onehot_decoder #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // Single bit set when enabled and the index names a real register.
  always_comb begin
    onehot = '0;
    if (en && ({1'b0, idx} < (IDX_W+1)'(NUM_REGS)))
      onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Hard-wired control sequencer: fetches an instruction over the datapath bus
// and steps the register-to-register ALU, unary and mul/div execution
// sequences. All strobes are Moore outputs of the state register.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int IR_W        = 32,
  parameter int OPCODE_W    = 5,
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zhighin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [OPCODE_W-1:0] opcode,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                bus_error
);

  localparam int RF_W    = $clog2(NUM_REGS);
  localparam int RA_HI   = IR_W - 1 - OPCODE_W;
  localparam int RB_HI   = RA_HI - RF_W;
  localparam int RC_HI   = RB_HI - RF_W;
  localparam int LOW_TOP = RC_HI - RF_W;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t              state, state_n;
  logic [7:0]          wait_cnt;

  // Instruction fields as presented by the datapath
  logic [OPCODE_W-1:0] ir_op;
  logic [RF_W-1:0]     ir_ra, ir_rb, ir_rc;
  op_class_t           dec_cls;

  // Fields captured when leaving T2, held for the execute steps
  logic [OPCODE_W-1:0] op_q;
  logic [RF_W-1:0]     ra_q, rb_q, rc_q;
  op_class_t           cls_q;

  // Register-select requests for the one-hot decoders
  logic                rin_en, rout_en;
  logic [RF_W-1:0]     rout_idx;

  logic                unused_ir_bits;

  assign ir_op = IR[IR_W-1 -: OPCODE_W];
  assign ir_ra = IR[RA_HI -: RF_W];
  assign ir_rb = IR[RB_HI -: RF_W];
  assign ir_rc = IR[RC_HI -: RF_W];
  assign unused_ir_bits = ^IR[LOW_TOP:0];

  // Classify the fetched word; any referenced register beyond the file is illegal.
  always_comb begin
    dec_cls = classify(ir_op);
    case (dec_cls)
      CLS_ALU:
        if (!reg_ok(ir_ra) || !reg_ok(ir_rb) || !reg_ok(ir_rc))
          dec_cls = CLS_ILLEGAL;
      CLS_MULDIV, CLS_UNARY:
        if (!reg_ok(ir_ra) || !reg_ok(ir_rb))
          dec_cls = CLS_ILLEGAL;
      default: ;
    endcase
  end

  function automatic logic reg_ok(input logic [RF_W-1:0] idx);
    return ({1'b0, idx} < (RF_W+1)'(NUM_REGS));
  endfunction

  // State register; clear forces IDLE immediately.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // Memory wait counter: counts T1W cycles, zero in every other state.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear)             wait_cnt <= '0;
    else if (state == T1W) wait_cnt <= wait_cnt + 8'd1;
    else                   wait_cnt <= '0;
  end

  // Capture decoded fields as the instruction leaves T2 so the execute
  // strobes depend only on registered state.
  always_ff @(posedge Clock) begin
    if (state == T2) begin
      op_q  <= ir_op;
      ra_q  <= ir_ra;
      rb_q  <= ir_rb;
      rc_q  <= ir_rc;
      cls_q <= dec_cls;
    end
  end

  // Next-state logic; start is only consulted in IDLE and terminal states.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = T0;
      T0:   state_n = T1;
      T1:   state_n = mem_ready ? T2 : T1W;
      T1W: begin
        if (mem_ready)                  state_n = T2;
        else if (wait_cnt == WAIT_LAST) state_n = ERR;
      end
      T2: begin
        case (dec_cls)
          CLS_ILLEGAL: state_n = TRAP;
          CLS_UNARY:   state_n = T4;
          default:     state_n = T3;
        endcase
      end
      T3: state_n = T4;
      T4: state_n = T5;
      T5: begin
        if (cls_q == CLS_MULDIV) state_n = T6;
        else                     state_n = start ? T0 : IDLE;
      end
      T6, TRAP, ERR: state_n = start ? T0 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore output decode from the state register and captured fields.
  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    opcode    = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    bus_error = 1'b0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rout_idx  = '0;
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Yin      = 1'b1;
        rout_en  = 1'b1;
        rout_idx = (cls_q == CLS_MULDIV) ? ra_q : rb_q;
      end
      T4: begin
        opcode   = op_q;
        Zlowin   = 1'b1;
        Zhighin  = 1'b1;
        rout_en  = 1'b1;
        rout_idx = (cls_q == CLS_ALU) ? rc_q : rb_q;
      end
      T5: begin
        Zlowout = 1'b1;
        if (cls_q == CLS_MULDIV) begin
          LOin = 1'b1;
        end else begin
          rin_en = 1'b1;
          done   = 1'b1;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      TRAP: illegal   = 1'b1;
      ERR:  bus_error = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .en     (rin_en),
    .idx    (ra_q),
    .onehot (reg_in)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (reg_out)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle strobe tables for each
// instruction class, plus hand sequences for memory timeout and clear.
module tb_alu_sequencer;

  logic        Clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  opcode;
  logic        busy, done, illegal, bus_error;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clock = ~Clock;

  alu_sequencer #(
    .IR_W(32), .OPCODE_W(5), .NUM_REGS(16), .MEM_TIMEOUT(4)
  ) dut (
    .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .reg_in(reg_in), .reg_out(reg_out), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal), .bus_error(bus_error)
  );

  // Flag bit positions in the packed strobe word
  localparam logic [18:0] F_PCOUT    = 19'd1 << 18;
  localparam logic [18:0] F_MARIN    = 19'd1 << 17;
  localparam logic [18:0] F_INCPC    = 19'd1 << 16;
  localparam logic [18:0] F_PCIN     = 19'd1 << 15;
  localparam logic [18:0] F_READ     = 19'd1 << 14;
  localparam logic [18:0] F_MDRIN    = 19'd1 << 13;
  localparam logic [18:0] F_MDROUT   = 19'd1 << 12;
  localparam logic [18:0] F_IRIN     = 19'd1 << 11;
  localparam logic [18:0] F_YIN      = 19'd1 << 10;
  localparam logic [18:0] F_ZLOWIN   = 19'd1 << 9;
  localparam logic [18:0] F_ZHIGHIN  = 19'd1 << 8;
  localparam logic [18:0] F_ZLOWOUT  = 19'd1 << 7;
  localparam logic [18:0] F_ZHIGHOUT = 19'd1 << 6;
  localparam logic [18:0] F_HIIN     = 19'd1 << 5;
  localparam logic [18:0] F_LOIN     = 19'd1 << 4;
  localparam logic [18:0] F_BUSY     = 19'd1 << 3;
  localparam logic [18:0] F_DONE     = 19'd1 << 2;
  localparam logic [18:0] F_ILL      = 19'd1 << 1;
  localparam logic [18:0] F_BERR     = 19'd1 << 0;

  localparam logic [18:0] FT0   = F_PCOUT | F_MARIN | F_INCPC | F_ZLOWIN | F_BUSY;
  localparam logic [18:0] FT1   = F_ZLOWOUT | F_PCIN | F_READ | F_MDRIN | F_BUSY;
  localparam logic [18:0] FT1W  = F_READ | F_MDRIN | F_BUSY;
  localparam logic [18:0] FT2   = F_MDROUT | F_IRIN | F_BUSY;
  localparam logic [18:0] FT3   = F_YIN | F_BUSY;
  localparam logic [18:0] FT4   = F_ZLOWIN | F_ZHIGHIN | F_BUSY;
  localparam logic [18:0] FT5A  = F_ZLOWOUT | F_DONE | F_BUSY;
  localparam logic [18:0] FT5M  = F_ZLOWOUT | F_LOIN | F_BUSY;
  localparam logic [18:0] FT6   = F_ZHIGHOUT | F_HIIN | F_DONE | F_BUSY;
  localparam logic [18:0] FTRAP = F_ILL | F_BUSY;
  localparam logic [18:0] FERR  = F_BERR | F_BUSY;

  localparam logic [31:0] IR_ADD = 32'h18918000;
  localparam logic [31:0] IR_MUL = 32'h7A280000;
  localparam logic [31:0] IR_NOT = 32'h93380000;
  localparam logic [31:0] IR_ILL = 32'hF8000000;

  typedef struct {
    logic        first;
    logic [31:0] ir;
    logic [18:0] flg;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic first, input logic [31:0] ir,
                              input logic [18:0] flg, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] opc);
    vec_t v;
    v.first = first; v.ir = ir; v.flg = flg;
    v.rin = rin; v.rout = rout; v.opc = opc;
    return v;
  endfunction

  function automatic logic [18:0] flags();
    return {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
            Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
            busy, done, illegal, bus_error};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic check_idle(input string nm);
    check({nm, " flags"},   32'(flags()), 32'h0);
    check({nm, " reg_in"},  32'(reg_in),  32'h0);
    check({nm, " reg_out"}, 32'(reg_out), 32'h0);
    check({nm, " opcode"},  32'(opcode),  32'h0);
  endtask

  // Assert clear, check the reset state, release on a falling edge.
  task automatic do_reset(input logic [31:0] ir, input logic mr);
    clear = 1'b1; start = 1'b1; mem_ready = mr; IR = ir;
    @(negedge Clock);
    check_idle("reset");
    clear = 1'b0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc_cnt;
    int seen;

    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; IR = '0;

    // add R1,R2,R3
    vecs.push_back(mk(1, IR_ADD, FT0,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ADD, FT1,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ADD, FT2,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ADD, FT3,  16'h0,    16'h0004, 5'h00));
    vecs.push_back(mk(0, IR_ADD, FT4,  16'h0,    16'h0008, 5'b00011));
    vecs.push_back(mk(0, IR_ADD, FT5A, 16'h0002, 16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ADD, FT0,  16'h0,    16'h0,    5'h00));
    // mul R4,R5
    vecs.push_back(mk(1, IR_MUL, FT0,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_MUL, FT1,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_MUL, FT2,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_MUL, FT3,  16'h0,    16'h0010, 5'h00));
    vecs.push_back(mk(0, IR_MUL, FT4,  16'h0,    16'h0020, 5'b01111));
    vecs.push_back(mk(0, IR_MUL, FT5M, 16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_MUL, FT6,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_MUL, FT0,  16'h0,    16'h0,    5'h00));
    // not R6,R7
    vecs.push_back(mk(1, IR_NOT, FT0,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_NOT, FT1,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_NOT, FT2,  16'h0,    16'h0,    5'h00));
    vecs.push_back(mk(0, IR_NOT, FT4,  16'h0,    16'h0080, 5'b10010));
    vecs.push_back(mk(0, IR_NOT, FT5A, 16'h0040, 16'h0,    5'h00));
    vecs.push_back(mk(0, IR_NOT, FT0,  16'h0,    16'h0,    5'h00));
    // illegal opcode 11111
    vecs.push_back(mk(1, IR_ILL, FT0,   16'h0,   16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ILL, FT1,   16'h0,   16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ILL, FT2,   16'h0,   16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ILL, FTRAP, 16'h0,   16'h0,    5'h00));
    vecs.push_back(mk(0, IR_ILL, FT0,   16'h0,   16'h0,    5'h00));

    foreach (vecs[i]) begin
      if (vecs[i].first) do_reset(vecs[i].ir, 1'b1);
      step();
      check($sformatf("v%0d flags", i),   32'(flags()),  32'(vecs[i].flg));
      check($sformatf("v%0d reg_in", i),  32'(reg_in),   32'(vecs[i].rin));
      check($sformatf("v%0d reg_out", i), 32'(reg_out),  32'(vecs[i].rout));
      check($sformatf("v%0d opcode", i),  32'(opcode),   32'(vecs[i].opc));
    end

    // Memory timeout: T1, four T1W, ERR for one cycle, then IDLE
    do_reset(IR_ADD, 1'b0);
    step(); check("to T0", 32'(flags()), 32'(FT0));
    start = 1'b0;
    step(); check("to T1", 32'(flags()), 32'(FT1));
    for (int k = 0; k < 4; k++) begin
      step(); check($sformatf("to T1W%0d", k), 32'(flags()), 32'(FT1W));
    end
    step(); check("to ERR", 32'(flags()), 32'(FERR));
    step(); check("to IDLE", 32'(flags()), 32'h0);

    // Second run: mem_ready rises during the second T1W
    start = 1'b1;
    pc_cnt = 0;
    step(); check("r2 T0", 32'(flags()), 32'(FT0)); pc_cnt += int'(PCin);
    start = 1'b0;
    step(); check("r2 T1", 32'(flags()), 32'(FT1)); pc_cnt += int'(PCin);
    step(); check("r2 T1W1", 32'(flags()), 32'(FT1W)); pc_cnt += int'(PCin);
    step(); check("r2 T1W2", 32'(flags()), 32'(FT1W)); pc_cnt += int'(PCin);
    mem_ready = 1'b1;
    step(); check("r2 T2", 32'(flags()), 32'(FT2)); pc_cnt += int'(PCin);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step();
      pc_cnt += int'(PCin);
      if (done) seen = 1;
    end
    check("r2 done seen", 32'(seen), 32'd1);
    check("r2 PCin pulses", 32'(pc_cnt), 32'd1);
    step(); check("r2 back to IDLE", 32'(flags()), 32'h0);

    // clear mid-execute (T4), then restart from T0
    do_reset(IR_ADD, 1'b1);
    repeat (5) step();
    check("clr pre T4 opcode", 32'(opcode), 32'b00011);
    clear = 1'b1;
    #1;
    check_idle("clr in T4");
    check("clr busy", 32'(busy), 32'd0);
    @(negedge Clock);
    clear = 1'b0;
    step(); check("clr restart T0", 32'(flags()), 32'(FT0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
